// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder among N_REQ requesters.
// Also holds adder_it1, the shared IEEE-754 binary32 adder (round-to-nearest-even).

module adder_it1 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    localparam int unsigned EXT_W = 27;

    logic             w_swap;
    logic [31:0]      w_x;
    logic [31:0]      w_y;
    logic [7:0]       w_ex;
    logic [7:0]       w_ey;
    logic [7:0]       w_d;
    logic [7:0]       w_emax;
    logic [7:0]       w_shift;
    logic [23:0]      w_mx;
    logic [23:0]      w_my;
    logic             w_x_nan;
    logic             w_y_nan;
    logic             w_x_inf;
    logic             w_y_inf;
    logic             w_sub;
    logic [EXT_W-1:0] w_ext_x;
    logic [EXT_W-1:0] w_ext_y;
    logic [EXT_W-1:0] w_aligned;
    logic [EXT_W:0]   w_sum;
    logic [4:0]       w_lz;
    logic [EXT_W-1:0] w_norm;
    logic [9:0]       w_exp_norm;
    logic [9:0]       w_exp_rnd;
    logic             w_round_up;
    logic [24:0]      w_m25;
    logic [23:0]      w_mant;
    logic             w_sign;

    // x always carries the larger magnitude so the exponent difference is non-negative
    assign w_swap  = i_b[30:0] > i_a[30:0];
    assign w_x     = w_swap ? i_b : i_a;
    assign w_y     = w_swap ? i_a : i_b;

    assign w_ex    = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
    assign w_ey    = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
    assign w_mx    = {w_x[30:23] != 8'd0, w_x[22:0]};
    assign w_my    = {w_y[30:23] != 8'd0, w_y[22:0]};
    assign w_x_nan = (&w_x[30:23]) & (|w_x[22:0]);
    assign w_y_nan = (&w_y[30:23]) & (|w_y[22:0]);
    assign w_x_inf = (&w_x[30:23]) & ~(|w_x[22:0]);
    assign w_y_inf = (&w_y[30:23]) & ~(|w_y[22:0]);
    assign w_d     = w_ex - w_ey;
    assign w_ext_x = {w_mx, 3'b000};
    assign w_ext_y = {w_my, 3'b000};
    assign w_sub   = w_x[31] ^ w_y[31];

    // Align the smaller operand, folding shifted-out bits into the sticky position
    always_comb begin
        w_aligned = '0;
        if (w_d >= 8'd27) begin
            w_aligned = EXT_W'(|w_my);
        end else begin
            w_aligned    = w_ext_y >> w_d;
            w_aligned[0] = w_aligned[0] | (|(w_ext_y & ~(27'h7FF_FFFF << w_d)));
        end
    end

    assign w_sum = w_sub ? ({1'b0, w_ext_x} - {1'b0, w_aligned})
                         : ({1'b0, w_ext_x} + {1'b0, w_aligned});

    always_comb begin
        w_lz = 5'd27;
        for (int i = 0; i < int'(EXT_W); i++) begin
            if (w_sum[i]) w_lz = 5'(26 - i);
        end
    end

    assign w_emax = w_ex - 8'd1;

    // Left shift is capped at exponent 1 so tiny results land as subnormals
    always_comb begin
        w_shift    = 8'd0;
        w_norm     = '0;
        w_exp_norm = '0;
        if (w_sum[EXT_W]) begin
            w_norm     = {w_sum[EXT_W:2], w_sum[1] | w_sum[0]};
            w_exp_norm = {2'b00, w_ex} + 10'd1;
        end else begin
            w_shift    = ({3'b000, w_lz} > w_emax) ? w_emax : {3'b000, w_lz};
            w_norm     = w_sum[EXT_W-1:0] << w_shift;
            w_exp_norm = {2'b00, w_ex - w_shift};
        end
    end

    assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_m25      = {1'b0, w_norm[26:3]} + 25'(w_round_up);
    assign w_mant     = w_m25[24] ? w_m25[24:1] : w_m25[23:0];
    assign w_exp_rnd  = w_exp_norm + 10'(w_m25[24]);
    assign w_sign     = (w_sum == '0) ? (w_x[31] & w_y[31]) : w_x[31];

    always_comb begin
        o_sum = {w_sign, w_exp_rnd[7:0], w_mant[22:0]};
        if (w_x_nan | w_y_nan | (w_x_inf & w_y_inf & w_sub)) begin
            o_sum = 32'h7FC0_0000;
        end else if (w_x_inf) begin
            o_sum = {w_x[31], 8'hFF, 23'd0};
        end else if (w_exp_rnd >= 10'd255) begin
            o_sum = {w_sign, 8'hFF, 23'd0};
        end else if (!w_mant[23]) begin
            o_sum = {w_sign, 8'd0, w_mant[22:0]};
        end
    end
endmodule

module fp_add_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_op1,
    input  logic [32*N_REQ-1:0]   req_op2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  busy
);
    localparam int unsigned DATA_W  = 32;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_EXEC = 2'd1;
    localparam logic [1:0]  ST_RESP = 2'd2;
    localparam logic [ID_W:0] N_REQ_X = (ID_W+1)'(N_REQ);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_valid;
    logic              r_busy;

    logic [N_REQ-1:0]  w_rot;
    logic              w_gnt_found;
    logic [ID_W-1:0]   w_gnt_off;
    logic [ID_W:0]     w_idx_sum;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [ID_W:0]     w_ptr_inc;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [DATA_W-1:0] w_sel_op1;
    logic [DATA_W-1:0] w_sel_op2;
    logic [N_REQ-1:0]  w_req_ready;
    logic              w_xfer;
    logic [DATA_W-1:0] w_add_sum;

    // Rotate request vector so bit 0 is the requester at rr_ptr
    always_comb begin
        w_rot = '0;
        for (int p = 0; p < int'(N_REQ); p++) begin
            if (r_rr_ptr == ID_W'(p)) begin
                for (int i = 0; i < int'(N_REQ); i++) begin
                    w_rot[i] = req_valid[(p + i) % int'(N_REQ)];
                end
            end
        end
    end

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_off   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_gnt_found = 1'b1;
                w_gnt_off   = ID_W'(i);
            end
        end
    end

    assign w_idx_sum = {1'b0, r_rr_ptr} + {1'b0, w_gnt_off};
    assign w_gnt_idx = (w_idx_sum >= N_REQ_X) ? ID_W'(w_idx_sum - N_REQ_X) : ID_W'(w_idx_sum);
    assign w_ptr_inc = {1'b0, w_gnt_idx} + (ID_W+1)'(1);
    assign w_ptr_nxt = (w_ptr_inc == N_REQ_X) ? '0 : ID_W'(w_ptr_inc);

    always_comb begin
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_sel_op1 = req_op1[DATA_W*i +: DATA_W];
                w_sel_op2 = req_op2[DATA_W*i +: DATA_W];
            end
        end
    end

    // Ready is withheld during reset so no requester believes a dropped transfer happened
    assign w_xfer = (r_state == ST_IDLE) & w_gnt_found & ~rst;

    always_comb begin
        w_req_ready = '0;
        if (w_xfer) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                w_req_ready[i] = (w_gnt_idx == ID_W'(i));
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_id         <= '0;
            r_rsp_result <= '0;
            r_rsp_id     <= '0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_op1    <= w_sel_op1;
                r_op2    <= w_sel_op2;
                r_id     <= w_gnt_idx;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_result <= w_add_sum;
                r_rsp_id     <= r_id;
            end
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    adder_it1 u_adder (
        .i_a   (r_op1),
        .i_b   (r_op2),
        .o_sum (w_add_sum)
    );

    assign req_ready  = w_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: arbitration order, latency, back-pressure and reset abort.

module tb_fp_add_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = 4'b0000;
    logic [3:0]   req_ready;
    logic [127:0] req_op1 = '0;
    logic [127:0] req_op2 = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    fp_add_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        logic [127:0] mask;
        mask    = {96'd0, 32'hFFFF_FFFF} << (32 * i);
        req_op1 = (req_op1 & ~mask) | ({96'd0, a} << (32 * i));
        req_op2 = (req_op2 & ~mask) | ({96'd0, b} << (32 * i));
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result: got %08h want 00000000", rsp_result); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %04b want 0000", req_ready); end
        n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.r_rr_ptr); end
    endtask

    task automatic test_single();
        set_ops(2, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 4'b0100; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %04b want 0100", req_ready); end
        tick(); req_valid = 4'b0000; #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_exec: got %0b want 1", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_exec: got %0b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_exec: got %04b want 0000", req_ready); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_resp: got %0b want 1", rsp_valid); end
        n_checks++; if (rsp_result !== 32'h4000_0000) begin n_fail++; $display("FAIL single_result: got %08h want 40000000", rsp_result); end
        n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", rsp_id); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_resp: got %0b want 1", busy); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %0b want 0", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_idle: got %0b want 0", rsp_valid); end
        n_checks++; if (dut.r_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL single_rr_ptr: got %0d want 3", dut.r_rr_ptr); end
    endtask

    task automatic test_pointer_wrap();
        set_ops(3, 32'h4000_0000, 32'hBF80_0000);
        set_ops(1, 32'h4040_0000, 32'h4040_0000);
        req_valid = 4'b1000; #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3: got %04b want 1000", req_ready); end
        tick(); req_valid = 4'b0000;
        tick();
        n_checks++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_id3: got %0d want 3", rsp_id); end
        n_checks++; if (rsp_result !== 32'h3F80_0000) begin n_fail++; $display("FAIL wrap_sub_result: got %08h want 3f800000", rsp_result); end
        tick();
        n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL wrap_rr_ptr: got %0d want 0", dut.r_rr_ptr); end
        req_valid = 4'b1010; #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_first: got %04b want 0010", req_ready); end
        tick(); req_valid = 4'b1000;
        tick();
        n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL wrap_id1: got %0d want 1", rsp_id); end
        n_checks++; if (rsp_result !== 32'h40C0_0000) begin n_fail++; $display("FAIL wrap_result1: got %08h want 40c00000", rsp_result); end
        tick();
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_second: got %04b want 1000", req_ready); end
        tick(); req_valid = 4'b0000;
        tick();
        n_checks++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_id3b: got %0d want 3", rsp_id); end
        tick();
    endtask

    task automatic test_round_robin();
        int unsigned last_cyc;
        last_cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 32'h3FC0_0000, 32'h4000_0000);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        tick(); rst = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_ready;
            logic [1:0] exp_id;
            exp_id    = 2'(k % 4);
            exp_ready = 4'b0001 << exp_id;
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_grant%0d: got %04b want %04b", k, req_ready, exp_ready); end
            tick(); tick();
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid%0d: got %0b want 1", k, rsp_valid); end
            n_checks++; if (rsp_result !== 32'h4060_0000) begin n_fail++; $display("FAIL rr_result%0d: got %08h want 40600000", k, rsp_result); end
            n_checks++; if (rsp_id !== exp_id) begin n_fail++; $display("FAIL rr_id%0d: got %0d want %0d", k, rsp_id, exp_id); end
            if (k > 0) begin
                n_checks++; if (cyc - last_cyc !== 3) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d want 3", k, cyc - last_cyc); end
            end
            last_cyc = cyc;
            tick();
        end
    endtask

    task automatic test_back_pressure();
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %04b want 0010", req_ready); end
        rsp_ready = 1'b0;
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_rise: got %0b want 1", rsp_valid); end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %0b want 1", c, rsp_valid); end
            n_checks++; if (rsp_result !== 32'h4060_0000) begin n_fail++; $display("FAIL bp_result%0d: got %08h want 40600000", c, rsp_result); end
            n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_id%0d: got %0d want 1", c, rsp_id); end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d: got %04b want 0000", c, req_ready); end
            n_checks++; if (dut.r_state !== 2'd2) begin n_fail++; $display("FAIL bp_state%0d: got %0d want 2", c, dut.r_state); end
        end
        rsp_ready = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %0b want 0", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant: got %04b want 0100", req_ready); end
        tick(); tick();
        n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_next_id: got %0d want 2", rsp_id); end
        tick(); req_valid = 4'b0000; #1;
    endtask

    task automatic test_withdrawn();
        set_ops(1, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 4'b1000;
        tick(); req_valid = 4'b0000;
        tick();
        rsp_ready = 1'b0; req_valid = 4'b0011; #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wd_ready_resp: got %04b want 0000", req_ready); end
        tick();
        req_valid = 4'b0010; rsp_ready = 1'b1;
        tick();
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wd_grant: got %04b want 0010", req_ready); end
        n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL wd_ptr_before: got %0d want 0", dut.r_rr_ptr); end
        tick(); req_valid = 4'b0000;
        n_checks++; if (dut.r_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL wd_ptr_after: got %0d want 2", dut.r_rr_ptr); end
        tick();
        n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL wd_id: got %0d want 1", rsp_id); end
        n_checks++; if (rsp_result !== 32'h4000_0000) begin n_fail++; $display("FAIL wd_result: got %08h want 40000000", rsp_result); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_ops(0, 32'h4040_0000, 32'h4040_0000);
        req_valid = 4'b0001; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_grant0: got %04b want 0001", req_ready); end
        tick(); req_valid = 4'b0000;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_exec: got %0b want 1", busy); end
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %0b want 0", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %0b want 0", rsp_valid); end
        n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL rm_result: got %08h want 00000000", rsp_result); end
        n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rm_rr_ptr: got %0d want 0", dut.r_rr_ptr); end
        n_checks++; if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL rm_state: got %0d want 0", dut.r_state); end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp%0d: got valid=%0b busy=%0b want 0 0", c, rsp_valid, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pointer_wrap();
        test_round_robin();
        test_back_pressure();
        test_withdrawn();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d cycles want fewer", cyc);
        $fatal(1, "timeout");
    end
endmodule
